// File: rtl/code_entry.sv
// code_entry: keypad code checker producing the seq/enable verdict pair for the alarm FSM
// Ports: clk, rst_n (async active-low), key_valid/key_val (decoded key strobe, 0-9 digit, C clear),
//        seq (registered verdict, 1 = match), enable (one-cycle verdict pulse),
//        digits (digits accepted in current entry), locked (lockout active).
// Optional feature: define CODE_LOCKOUT_EN to lock the keypad after MAX_FAIL consecutive wrong codes.
module code_entry #(
  parameter int CODE_LEN = 4,
  parameter logic [31:0] CODE = 32'h0000_1234,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic       seq,
  output logic       enable,
  output logic [3:0] digits,
  output logic       locked
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST = 4'(CODE_LEN - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, VERDICT, LOCKED} state_t;
  state_t state;
  logic mismatch;
  logic [TW-1:0] timer;
  logic is_digit, is_clear, miss;
  logic [3:0] sel, exp_digit;
  assign is_digit = key_valid && key_val <= 4'd9;
  assign is_clear = key_valid && key_val == 4'hC;
  // first digit lives in the most significant used nibble
  assign sel = LAST - digits;
  assign exp_digit = 4'(CODE >> {sel, 2'b00});
  assign miss = mismatch | (key_val != exp_digit);
`ifdef CODE_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_timer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      seq <= 1'b0;
      enable <= 1'b0;
      digits <= 4'd0;
      mismatch <= 1'b0;
      timer <= '0;
      locked <= 1'b0;
      fail_cnt <= '0;
      lock_timer <= '0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE, COLLECT:
          if (is_digit) begin
            digits <= digits + 4'd1;
            mismatch <= miss;
            timer <= '0;
            if (digits == LAST) begin
              state <= VERDICT;
              enable <= 1'b1;
              seq <= !miss;
              fail_cnt <= miss ? fail_cnt + 1'b1 : '0;
            end else state <= COLLECT;
          end else if (state == COLLECT && (is_clear || timer == TMAX)) begin
            state <= IDLE;
            digits <= 4'd0;
            mismatch <= 1'b0;
            timer <= '0;
          end else if (state == COLLECT) timer <= timer + 1'b1;
        VERDICT: begin
          digits <= 4'd0;
          mismatch <= 1'b0;
          if (fail_cnt == FW'(MAX_FAIL)) begin
            state <= LOCKED;
            locked <= 1'b1;
            lock_timer <= '0;
          end else state <= IDLE;
        end
        default:
          if (lock_timer == LW'(LOCK_CYCLES - 1)) begin
            state <= IDLE;
            locked <= 1'b0;
            fail_cnt <= '0;
          end else lock_timer <= lock_timer + 1'b1;
      endcase
    end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_FAIL), 32'(LOCK_CYCLES)};
  assign locked = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      seq <= 1'b0;
      enable <= 1'b0;
      digits <= 4'd0;
      mismatch <= 1'b0;
      timer <= '0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE, COLLECT:
          if (is_digit) begin
            digits <= digits + 4'd1;
            mismatch <= miss;
            timer <= '0;
            if (digits == LAST) begin
              state <= VERDICT;
              enable <= 1'b1;
              seq <= !miss;
            end else state <= COLLECT;
          end else if (state == COLLECT && (is_clear || timer == TMAX)) begin
            state <= IDLE;
            digits <= 4'd0;
            mismatch <= 1'b0;
            timer <= '0;
          end else if (state == COLLECT) timer <= timer + 1'b1;
        VERDICT: begin
          digits <= 4'd0;
          mismatch <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`endif
endmodule

// File: tb/tb_code_entry.sv
// tb_code_entry: randomized self-checking bench for code_entry against a digit-queue reference model
module tb_code_entry;
  localparam int CODE_LEN = 4;
  localparam logic [31:0] CODE = 32'h0000_1234;
  localparam int TO = 20;
  localparam int LK = 30;
  localparam int MF = 3;
`ifdef CODE_LOCKOUT_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic key_valid = 1'b0;
  logic [3:0] key_val = 4'd0;
  logic seq, enable, locked;
  logic [3:0] digits;
  int errors = 0;
  int checks = 0;
  code_entry #(
    .CODE_LEN(CODE_LEN),
    .CODE(CODE),
    .TIMEOUT_CYCLES(TO),
    .MAX_FAIL(MF),
    .LOCK_CYCLES(LK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_val(key_val),
    .seq(seq),
    .enable(enable),
    .digits(digits),
    .locked(locked)
  );
  always #5 clk = ~clk;
  logic [3:0] entry[$];
  int idle_run = 0;
  int lock_left = 0;
  int fails = 0;
  logic verdict_pending = 1'b0;
  logic m_seq = 1'b0;
  logic m_en = 1'b0;
  function automatic logic [3:0] code_digit(input int i);
    return 4'((CODE >> (4 * (CODE_LEN - 1 - i))) & 32'hF);
  endfunction
  function automatic logic entry_matches();
    for (int i = 0; i < CODE_LEN; i++)
      if (entry[i] != code_digit(i)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction
  // reference: the entry is a queue of typed digits, judged as a whole once full
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry.delete();
      idle_run = 0;
      lock_left = 0;
      fails = 0;
      verdict_pending = 1'b0;
      m_seq = 1'b0;
      m_en = 1'b0;
    end else begin
      m_en = 1'b0;
      if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) fails = 0;
      end else if (verdict_pending) begin
        verdict_pending = 1'b0;
        entry.delete();
        if (LOCK_ON && fails == MF) lock_left = LK;
      end else if (key_valid && key_val <= 4'd9) begin
        entry.push_back(key_val);
        idle_run = 0;
        if (entry.size() == CODE_LEN) begin
          m_seq = entry_matches();
          m_en = 1'b1;
          verdict_pending = 1'b1;
          fails = m_seq ? 0 : fails + 1;
        end
      end else if (entry.size() > 0) begin
        if (key_valid && key_val == 4'hC) entry.delete();
        else if (idle_run == TO - 1) entry.delete();
        else idle_run++;
      end
    end
  end
  always @(negedge clk) begin
    chk("seq", seq, m_seq);
    chk("enable", enable, m_en);
    chk("digits", digits, entry.size());
    chk("locked", locked, LOCK_ON && lock_left > 0);
  end
  task automatic key(input logic [3:0] v);
    key_valid = 1'b1;
    key_val = v;
    @(posedge clk);
    #2 key_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    #30000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int r;
    logic [3:0] v;
    #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("lit_rst_seq", seq, 0);
    chk("lit_rst_en", enable, 0);
    chk("lit_rst_digits", digits, 0);
    chk("lit_rst_locked", locked, 0);
    idle(1);
    key(1); key(2); key(3); key(4);
    #1;
    chk("lit_match_en", enable, 1);
    chk("lit_match_seq", seq, 1);
    idle(1);
    #1;
    chk("lit_match_en_off", enable, 0);
    chk("lit_match_digits0", digits, 0);
    chk("lit_match_seq_hold", seq, 1);
    key(1); key(2); key(9);
    #1;
    chk("lit_nomatch_early", enable, 0);
    chk("lit_nomatch_digits3", digits, 3);
    key(4);
    #1;
    chk("lit_nomatch_en", enable, 1);
    chk("lit_nomatch_seq", seq, 0);
    idle(1);
    key(1); key(2); key(4'hC);
    #1;
    chk("lit_clear_digits", digits, 0);
    chk("lit_clear_en", enable, 0);
    key(1); key(2); key(3); key(4);
    #1;
    chk("lit_clear_then_match", enable, 1);
    chk("lit_clear_then_seq", seq, 1);
    idle(1);
    key(1); key(2);
    idle(TO);
    #1;
    chk("lit_timeout_digits", digits, 0);
    key(3); key(4);
    #1;
    chk("lit_timeout_no_pulse", enable, 0);
    chk("lit_timeout_digits2", digits, 2);
    key(4'hC);
    key(1); key(2);
    idle(TO - 1);
    key(3);
    #1;
    chk("lit_expiry_key_wins", digits, 3);
    key(4'hC);
    key(1); key(2); key(3);
    #1 rst_n = 1'b0;
    #1;
    chk("lit_async_rst_digits", digits, 0);
    chk("lit_async_rst_seq", seq, 0);
    chk("lit_async_rst_en", enable, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    key(4);
    #1;
    chk("lit_post_rst_digits", digits, 1);
    chk("lit_post_rst_en", enable, 0);
    key(4'hC);
    idle(1);
    repeat (3) begin
      key(0); key(0); key(0); key(0);
      #1;
      chk("lit_fail_en", enable, 1);
      chk("lit_fail_seq", seq, 0);
      idle(1);
    end
    #1;
    chk("lit_locked", locked, LOCK_ON);
    key(1); key(2); key(3); key(4);
    #1;
    chk("lit_locked_entry_en", enable, !LOCK_ON);
    idle(1);
    idle(LK);
    #1;
    chk("lit_unlocked", locked, 0);
    key(1); key(2); key(3); key(4);
    #1;
    chk("lit_after_lock_en", enable, 1);
    chk("lit_after_lock_seq", seq, 1);
    idle(1);
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        idle(1);
      end else if (r < 20) idle($urandom_range(15, 35));
      else if (r < 550) begin
        v = $urandom_range(0, 2) != 0 ? code_digit(entry.size() % CODE_LEN) : 4'($urandom_range(0, 15));
        key(v);
      end else idle(1);
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/code_entry.md
# code_entry

Keypad code checker that produces the `seq`/`enable` pair consumed by the alarm state machine. It accepts decoded key strobes and compares a fixed-length digit sequence against a compile-time code. On the last digit it issues a single-cycle `enable` pulse, with `seq` high on match and low on mismatch. It sits between the keypad scanner/debouncer and the alarm FSM; both run on the same clock.

## Interface
Parameters:
- `CODE_LEN`, 4: digits per code, 1..8.
- `CODE`, 32'h0000_1234: expected code, 4 bits per digit, first digit in the most significant used nibble (`CODE[4*CODE_LEN-1 -: 4]`); upper unused nibbles are ignored.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles allowed between digits before the entry is discarded; must be ≥1.
- `MAX_FAIL`, 3: consecutive wrong codes that trigger lockout; only used with `CODE_LOCKOUT_EN`.
- `LOCK_CYCLES`, 500_000_000: lockout duration; only used with `CODE_LOCKOUT_EN`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `key_valid` in 1: one-cycle strobe; `key_val` is sampled when this is high.
- `key_val` in 4: 0–9 are digits; 4'hC is clear; all other values are ignored.
- `seq` out 1: verdict, 1 = code matched; registered; holds the last verdict.
- `enable` out 1: one-cycle pulse marking a new verdict on `seq`.
- `digits` out 4: count of digits accepted in the current entry.
- `locked` out 1: lockout active; constant 0 without `CODE_LOCKOUT_EN`.

## Operation
- States: IDLE (no digits), COLLECT (1..CODE_LEN-1 digits), VERDICT (one cycle, pulse out), LOCKED (macro only).
- Reset: state IDLE; `seq`=0, `enable`=0, `digits`=0, `locked`=0, mismatch flag cleared, timer 0, fail count 0.
- Digits are compared one at a time against the nibble at index `digits`. A sticky mismatch flag ORs in any difference, so no digit storage is needed.
- IDLE or COLLECT, digit key: increment `digits`, update the mismatch flag, reset the timer. If it is digit number CODE_LEN, go to VERDICT.
- VERDICT: `enable`=1 and `seq`=!mismatch for exactly one cycle. Then clear `digits` and the flag, and go to IDLE, or to LOCKED per the rules below. Keys arriving in VERDICT are dropped.
- Clear key (4'hC) in COLLECT: return to IDLE, no pulse, `seq` unchanged. In IDLE it has no effect.
- Ignored codes (A, B, D, E, F): no state change and no timer reset.
- Timeout: the timer runs only in COLLECT. When it reaches TIMEOUT_CYCLES-1 with no key in that cycle, go to IDLE, discard the entry, emit no pulse, and count no failure.
- Simultaneous key and timeout expiry: the key wins and the timer restarts.
- CODE_LEN=1: the first digit goes directly to VERDICT.
- Timer width is $clog2(TIMEOUT_CYCLES+1); lock timer width is $clog2(LOCK_CYCLES+1).

## Timing
- The digit that completes the code is sampled on edge N. `enable`=1 and the new `seq` are both visible during cycle N+1, high for one cycle. The next key is accepted from edge N+2.
- Back-to-back `key_valid` on consecutive cycles is accepted each cycle, except while in VERDICT and LOCKED.
- Reset assertion takes effect immediately, mid-entry or mid-lockout, and forces all outputs to their reset values.

## Configuration
- Macro: `CODE_LOCKOUT_EN`.
- Defined:
  - The fail counter increments on each `seq`=0 verdict and clears on `seq`=1.
  - A failing verdict that brings the count to MAX_FAIL still emits its pulse, then goes to LOCKED.
  - LOCKED: `locked`=1, all keys dropped, runs for LOCK_CYCLES cycles, then returns to IDLE with the fail count cleared and `locked`=0.
- Undefined: no fail counter, no lock timer, and no LOCKED state; `locked` is tied to 0 and VERDICT always returns to IDLE.

## Test plan
All scenarios use default parameters, TIMEOUT_CYCLES=20 and LOCK_CYCLES=30.
- Keys 1,2,3,4 on consecutive cycles -> `enable` pulses for exactly one cycle, one cycle after the key 4 strobe, with `seq`=1; then `digits`=0.
- Keys 1,2,9,4 -> one `enable` pulse with `seq`=0; the mismatch in the third digit is not flagged early, so there is no pulse before the fourth digit.
- Keys 1,2, then C, then 1,2,3,4 -> no pulse after C; a single match pulse at the end.
- Keys 1,2, then 20 idle cycles, then 3,4 -> timeout returns to IDLE with `digits`=0 and no pulse after 3,4. Key 3 sent on the expiry cycle instead is accepted and `digits`=3.
- Reset asserted after keys 1,2,3 -> outputs are immediately 0. After release, 4 alone gives no pulse and `digits`=1.
- With `CODE_LOCKOUT_EN`, three 0000 entries -> three `seq`=0 pulses, then `locked`=1 for 30 cycles. 1,2,3,4 entered during lockout gives no pulse; entered after lockout it gives `seq`=1. Without the macro, the same stimulus leaves `locked`=0 and the fourth entry matches.
